// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: character width, per-entry
// error-bit positions and the width of one buffered entry.
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int ERR_PAR      = 0;
    localparam int ERR_FRM      = 1;
    localparam int UART_ENTRY_W = UART_DATA_W + 2;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receiver/host logic and the receive FIFO.
// master = the side feeding frames and consuming bytes, slave = the FIFO.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = 4
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_par_err;
    logic              rx_frm_err;
    logic              rd_ready;
    logic              clr_ovf;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        rd_err;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              overflow;

    modport master (
        output rx_valid, rx_data, rx_par_err, rx_frm_err, rd_ready, clr_ovf,
        input  rd_valid, rd_data, rd_err, count, empty, full, almost_full, overflow
    );

    modport slave (
        input  rx_valid, rx_data, rx_par_err, rx_frm_err, rd_ready, clr_ovf,
        output rd_valid, rd_data, rd_err, count, empty, full, almost_full, overflow
    );

endinterface : uart_rx_fifo_if

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read
// port so the FIFO head can fall through without a read latency.
module fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 10
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming entry on the write strobe.
    // NOTE: the array has no reset; entries are only ever read after being
    // written, and the empty gating hides stale contents at the output.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through buffer for received UART frames. Holds pointers,
// occupancy, status flags and the sticky overflow bit; storage is in fifo_mem.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic           clock,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);

    localparam int              ENTRY_W = DATA_W + 2;
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W + 1)'(AFULL_LVL);

    logic [ADDR_W:0]    wr_ptr, rd_ptr, count_q;
    logic [ADDR_W:0]    wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic               empty_q, full_q, afull_q, ovf_q;
    logic               wr_en, rd_en, ovf_evt;
    logic [ENTRY_W-1:0] wdata, rdata;

    // Handshake decode, entry packing and next pointer/occupancy values.
    // NOTE: every output of this block is assigned a default first, so no
    // path leaves a value held and no latch is inferred.
    always_comb begin
        rd_en      = !empty_q && bus.rd_ready;
        wr_en      = bus.rx_valid && (!full_q || rd_en);
        ovf_evt    = bus.rx_valid && full_q && !rd_en;

        wdata                  = '0;
        wdata[DATA_W-1:0]      = bus.rx_data;
        wdata[DATA_W+ERR_PAR]  = bus.rx_par_err;
        wdata[DATA_W+ERR_FRM]  = bus.rx_frm_err;

        wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, wr_en};
        rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, rd_en};

        count_nxt  = count_q;
        if (wr_en && !rd_en) begin
            count_nxt = count_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_nxt = count_q - 1'b1;
        end
    end

    // Pointer, occupancy and flag registers, all moving on the same edge.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            empty_q <= (wr_ptr_nxt == rd_ptr_nxt);
            full_q  <= (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                       (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);
            afull_q <= (count_nxt >= AFULL_C);
        end
    end

    // Sticky overflow: a dropped frame sets it, clr_ovf clears it, set wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (ovf_evt) begin
            ovf_q <= 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (ENTRY_W)
    ) u_mem (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rdata)
    );

    // Head entry falls through combinationally, forced to zero when empty.
    assign bus.rd_valid    = !empty_q;
    assign bus.rd_data     = empty_q ? '0 : rdata[DATA_W-1:0];
    assign bus.rd_err      = empty_q ? 2'b00
                                     : {rdata[DATA_W+ERR_FRM], rdata[DATA_W+ERR_PAR]};
    assign bus.count       = count_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = afull_q;
    assign bus.overflow    = ovf_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random
// traffic, compared against a queue-based model of the buffer.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    uart_rx_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    uart_rx_fifo #(
        .DATA_W    (8),
        .DEPTH     (DEPTH),
        .ADDR_W    (4),
        .AFULL_LVL (AFULL)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: queue of {frm, par, data} entries and the sticky flag.
    logic [9:0] mq[$];
    bit         m_ovf;

    // Copies of what was driven this cycle, used by the model.
    bit         d_v, d_par, d_frm, d_rdy, d_clr;
    logic [7:0] d_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [9:0] head;
        int sz;
        sz   = mq.size();
        head = (sz > 0) ? mq[0] : 10'h000;
        check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(sz > 0));
        check({tag, ".rd_data"},  32'(bus.rd_data),  32'(head[7:0]));
        check({tag, ".rd_err"},   32'(bus.rd_err),   32'(head[9:8]));
        check({tag, ".count"},    32'(bus.count),    32'(sz));
        check({tag, ".empty"},    32'(bus.empty),    32'(sz == 0));
        check({tag, ".full"},     32'(bus.full),     32'(sz == DEPTH));
        check({tag, ".afull"},    32'(bus.almost_full), 32'(sz >= AFULL));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit par, input bit frm,
                         input bit rdy, input bit clr);
        d_v = v; d_data = d; d_par = par; d_frm = frm; d_rdy = rdy; d_clr = clr;
        bus.rx_valid   = v;
        bus.rx_data    = d;
        bus.rx_par_err = par;
        bus.rx_frm_err = frm;
        bus.rd_ready   = rdy;
        bus.clr_ovf    = clr;
    endtask

    // Advance one clock, update the model from the driven inputs, compare.
    task automatic tick(input string tag);
        int sz;
        bit rd, wr, ev;
        @(posedge clock);
        sz = mq.size();
        rd = (sz > 0) && d_rdy;
        wr = d_v && ((sz < DEPTH) || rd);
        ev = d_v && (sz == DEPTH) && !rd;
        if (rd) void'(mq.pop_front());
        if (wr) mq.push_back({d_frm, d_par, d_data});
        if (ev) m_ovf = 1'b1;
        else if (d_clr) m_ovf = 1'b0;
        #1;
        check_all(tag);
    endtask

    task automatic wr_byte(input logic [7:0] d, input bit par, input bit frm, input string tag);
        drive(1'b1, d, par, frm, 1'b0, 1'b0);
        tick(tag);
    endtask

    task automatic rd_byte(input string tag);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(tag);
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(tag);
    endtask

    initial begin
        logic [7:0] r;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        m_ovf = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        reset = 1'b0;

        // 1: single write, fall-through after one cycle
        wr_byte(8'hA5, 1'b0, 1'b0, "t1.wr");
        check("t1.valid", 32'(bus.rd_valid), 32'd1);
        check("t1.data",  32'(bus.rd_data),  32'hA5);
        check("t1.err",   32'(bus.rd_err),   32'd0);
        check("t1.count", 32'(bus.count),    32'd1);
        rd_byte("t1.rd");

        // 2: fill, almost_full/full thresholds, overflow drop, ordered drain
        for (int i = 0; i < DEPTH; i++) begin
            wr_byte(8'(i), 1'b0, 1'b0, "t2.fill");
            check("t2.afull", 32'(bus.almost_full), 32'((i + 1) >= 12));
            check("t2.full",  32'(bus.full),        32'((i + 1) == 16));
        end
        wr_byte(8'hFF, 1'b0, 1'b0, "t2.ovf");
        check("t2.ovf_set", 32'(bus.overflow), 32'd1);
        check("t2.ovf_cnt", 32'(bus.count),    32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            check("t2.drain", 32'(bus.rd_data), 32'(i));
            rd_byte("t2.rd");
        end
        check("t2.empty", 32'(bus.empty), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("t2.clr");
        check("t2.ovf_clr", 32'(bus.overflow), 32'd0);

        // 3: write while full and draining is accepted
        for (int i = 0; i < DEPTH; i++) wr_byte(8'(i), 1'b0, 1'b0, "t3.fill");
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("t3.rw");
        check("t3.count", 32'(bus.count),    32'd16);
        check("t3.ovf",   32'(bus.overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            check("t3.drain", 32'(bus.rd_data), (i < 15) ? 32'(i + 1) : 32'h55);
            rd_byte("t3.rd");
        end

        // 4: per-entry error bits
        wr_byte(8'h3C, 1'b1, 1'b0, "t4.wr_par");
        wr_byte(8'hC3, 1'b0, 1'b1, "t4.wr_frm");
        check("t4.err0",  32'(bus.rd_err),  32'b01);
        check("t4.data0", 32'(bus.rd_data), 32'h3C);
        rd_byte("t4.rd0");
        check("t4.err1",  32'(bus.rd_err),  32'b10);
        check("t4.data1", 32'(bus.rd_data), 32'hC3);
        rd_byte("t4.rd1");

        // 5: write/read pairs across pointer wrap, then random traffic
        for (int k = 0; k < 40; k++) begin
            r = 8'($urandom);
            wr_byte(r, 1'b0, 1'b0, "t5.pair_wr");
            check("t5.pair_data", 32'(bus.rd_data), 32'(r));
            rd_byte("t5.pair_rd");
        end
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 1) == 1), 8'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            tick("t5.rand");
        end
        while (mq.size() < DEPTH) wr_byte(8'($urandom), 1'b0, 1'b0, "t5.fill");
        drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("t5.set_clr");
        check("t5.set_wins", 32'(bus.overflow), 32'd1);

        // 6: asynchronous reset between edges, then fresh traffic
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick("t6.clr");
        while (mq.size() > 0) rd_byte("t6.drain");
        for (int i = 0; i < 5; i++) wr_byte(8'(8'h10 + i), 1'b0, 1'b0, "t6.load");
        idle("t6.idle");
        #3;
        reset = 1'b1;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        check("t6.empty", 32'(bus.empty),    32'd1);
        check("t6.count", 32'(bus.count),    32'd0);
        check("t6.data",  32'(bus.rd_data),  32'd0);
        check("t6.valid", 32'(bus.rd_valid), 32'd0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_all("t6.post");
        wr_byte(8'h7E, 1'b0, 1'b0, "t6.wr");
        check("t6.next", 32'(bus.rd_data), 32'h7E);
        rd_byte("t6.rd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of uart_rx. It captures each completed 8-bit frame from the receiver's output, together with its parity and stop-bit status, into a first-word-fall-through FIFO. The FIFO presents a valid/ready read interface to the host-side logic. It decouples the 9600-baud receive rate from the consumer and reports overflow when the consumer falls behind.

Parameters:
DATA_W, 8, width of one received character (matches rx_out)
DEPTH, 16, number of entries; must be a power of two
ADDR_W, 4, log2(DEPTH)
AFULL_LVL, 12, occupancy at or above which almost_full asserts

Ports:
clock  input  1  system clock, shared with uart_rx
reset  input  1  asynchronous, active-high reset
rx_valid  input  1  one-cycle pulse from the receiver control path when a frame has completed
rx_data  input  DATA_W  received byte (uart_rx rx_out), valid when rx_valid=1
rx_par_err  input  1  parity check failed for this frame
rx_frm_err  input  1  stop bit sampled low for this frame
rd_ready  input  1  consumer accepts the head entry this cycle
rd_valid  output  1  head entry available (equals !empty)
rd_data  output  DATA_W  head byte; forced to 0 when empty
rd_err  output  2  head entry status {frm_err, par_err}; forced to 0 when empty
count  output  ADDR_W+1  current occupancy, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
almost_full  output  1  count>=AFULL_LVL
overflow  output  1  sticky: a frame arrived while full and not draining
clr_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset (async, active-high). wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, overflow=0, rd_valid=0, rd_data=0, rd_err=0. Storage array is not reset.
- Pointers are ADDR_W+1 bits and wrap modulo 2*DEPTH. Index = low ADDR_W bits.
  - full when the index bits are equal and the MSBs differ.
  - empty when the pointers are equal.
- Each entry is DATA_W+2 bits: {frm_err, par_err, data}.
- Write: wr_en = rx_valid & (!full | rd_en). On wr_en, the entry is stored at wr_ptr[ADDR_W-1:0] and wr_ptr increments.
- Read: rd_en = rd_valid & rd_ready. On rd_en, rd_ptr increments. rd_ready while empty is ignored.
- FWFT: rd_data/rd_err are driven combinationally from mem[rd_ptr], gated by !empty. A write into an empty FIFO makes rd_valid=1 on the next cycle (latency 1). There is no same-cycle bypass.
- Simultaneous read and write:
  - Count is unchanged.
  - When full, the write is accepted because the head is leaving.
  - When empty, only the write takes effect.
- Overflow: rx_valid & full & !rd_en drops the frame, leaves pointers unchanged, and sets overflow=1 on the next edge. It stays set until a cycle with clr_ovf=1. If clr_ovf and a new overflow event occur in the same cycle, set wins.
- Status: count, empty, full and almost_full are registered and updated on the same edge as the pointers. Consistency invariant: empty == (count==0) and full == (count==DEPTH) on every cycle.
- Error bits are stored per entry only. They do not affect flow control.
- Reset mid-operation: all contents are discarded immediately, regardless of clock.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W=8
  - error-bit indices ERR_PAR=0, ERR_FRM=1
  - entry width constant UART_ENTRY_W = UART_DATA_W+2
- Sub-module fifo_mem: DEPTH x UART_ENTRY_W register array with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata). uart_rx_fifo holds the pointers, counter, flags and overflow logic.

Test Plan:
1. Reset, then write 0xA5 (no errors), rd_ready=0 -> rd_valid=1 one cycle later, rd_data=0xA5, rd_err=2'b00, count=1.
2. Write 16 bytes 0x00..0x0F with rd_ready=0 -> almost_full rises at count=12, full=1 at 16. A 17th write of 0xFF gives overflow=1 and count stays 16. Draining returns 0x00..0x0F in order; 0xFF is never seen.
3. Fill to full, then pulse rx_valid=0x55 together with rd_ready=1 -> head 0x00 leaves, 0x55 is stored, count stays 16, overflow stays 0. The final drained byte is 0x55.
4. Write 0x3C with rx_par_err=1, then 0xC3 with rx_frm_err=1 -> rd_err reads 2'b01 then 2'b10 alongside the matching data.
5. Run 40 write/read pairs to cross pointer wrap twice with random data -> scoreboard matches, empty/full never spuriously assert. Then assert overflow and clr_ovf in the same cycle -> overflow remains 1.
6. Load 5 entries, assert reset asynchronously between clock edges -> empty=1, count=0, rd_data=0 immediately. After release, a new write of 0x7E is the next byte read.
